// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with stall hold, bubble insertion, exception/ERET
// redirect, optional Tnew countdown and a saturating bubble counter.
module pipe_stage_reg #(
    parameter int          PAYLOAD_W  = 128,
    parameter int          TNEW_W     = 2,
    parameter bit          DEC_TNEW   = 1'b1,
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter int          CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req,
    input  logic                 eret,
    input  logic [31:0]          epc,
    input  logic                 stall,
    input  logic                 bubble,
    input  logic                 in_valid,
    input  logic [31:0]          in_pc,
    input  logic                 in_bd,
    input  logic [4:0]           in_exccode,
    input  logic [TNEW_W-1:0]    in_tnew,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 out_valid,
    output logic [31:0]          out_pc,
    output logic                 out_bd,
    output logic [4:0]           out_exccode,
    output logic [TNEW_W-1:0]    out_tnew,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [CNT_W-1:0]     bubble_cnt
);

    logic                 valid_q,   valid_d;
    logic [31:0]          pc_q,      pc_d;
    logic                 bd_q,      bd_d;
    logic [4:0]           exccode_q, exccode_d;
    logic [TNEW_W-1:0]    tnew_q,    tnew_d;
    logic [PAYLOAD_W-1:0] payload_q, payload_d;
    logic [CNT_W-1:0]     cnt_q,     cnt_d;

    logic [TNEW_W-1:0]    tnew_load;

    // Tnew counts down toward zero but never wraps past it.
    assign tnew_load = (DEC_TNEW && (in_tnew != '0)) ? in_tnew - TNEW_W'(1) : in_tnew;

    always_comb begin
        valid_d   = valid_q;
        pc_d      = pc_q;
        bd_d      = bd_q;
        exccode_d = exccode_q;
        tnew_d    = tnew_q;
        payload_d = payload_q;
        cnt_d     = cnt_q;
        if (req || eret) begin
            // Redirects override stall; exccode cleared so the flushed slot stays silent.
            pc_d      = req ? HANDLER_PC : epc;
            valid_d   = 1'b0;
            bd_d      = 1'b0;
            exccode_d = '0;
            tnew_d    = '0;
            payload_d = '0;
        end else if (stall) begin
            // Hold everything, including the Tnew countdown.
        end else if (bubble) begin
            // PC and BD survive so a later exception still reports a correct EPC/BD.
            pc_d      = in_pc;
            bd_d      = in_bd;
            valid_d   = 1'b0;
            exccode_d = '0;
            tnew_d    = '0;
            payload_d = '0;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            valid_d   = in_valid;
            pc_d      = in_pc;
            bd_d      = in_bd;
            exccode_d = in_exccode;
            tnew_d    = tnew_load;
            payload_d = in_payload;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= 1'b0;
            pc_q      <= RESET_PC;
            bd_q      <= 1'b0;
            exccode_q <= '0;
            tnew_q    <= '0;
            payload_q <= '0;
            cnt_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            pc_q      <= pc_d;
            bd_q      <= bd_d;
            exccode_q <= exccode_d;
            tnew_q    <= tnew_d;
            payload_q <= payload_d;
            cnt_q     <= cnt_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_pc      = pc_q;
    assign out_bd      = bd_q;
    assign out_exccode = exccode_q;
    assign out_tnew    = tnew_q;
    assign out_payload = payload_q;
    assign bubble_cnt  = cnt_q;

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register for the exception-capable 5-stage MIPS core.
- One module replaces the per-stage register files (D/E, E/M, M/W).
- Carries PC, branch-delay flag, exception code, Tnew and an opaque payload bus.
- Adds stall-hold, bubble insertion with PC preservation, an exception redirect, an ERET redirect, a configurable Tnew countdown, a valid bit and a saturating bubble counter.

Parameters:
- PAYLOAD_W, 128: width of the opaque control/data payload (ALU result, RD2, A3, write selects, etc.).
- TNEW_W, 2: width of the Tnew field.
- DEC_TNEW, 1: 1 = Tnew decrements by 1 on load, saturating at 0; 0 = Tnew passes through unchanged.
- RESET_PC, 32'h0000_3000: PC value loaded on reset.
- HANDLER_PC, 32'h0000_4180: PC value loaded on an exception request.
- CNT_W, 16: width of the bubble counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  1  exception/interrupt request; flush and redirect to HANDLER_PC.
- eret  in  1  ERET commit; flush and redirect to epc.
- epc  in  32  EPC value from CP0.
- stall  in  1  hold every field unchanged.
- bubble  in  1  load a bubble while keeping the PC and BD of the incoming instruction.
- in_valid  in  1  upstream slot holds a real instruction.
- in_pc  in  32  upstream PC.
- in_bd  in  1  upstream branch-delay flag.
- in_exccode  in  5  upstream exception code.
- in_tnew  in  TNEW_W  upstream Tnew.
- in_payload  in  PAYLOAD_W  upstream payload.
- out_valid  out  1  registered valid.
- out_pc  out  32  registered PC.
- out_bd  out  1  registered BD.
- out_exccode  out  5  registered exception code.
- out_tnew  out  TNEW_W  registered Tnew.
- out_payload  out  PAYLOAD_W  registered payload.
- bubble_cnt  out  CNT_W  number of bubble-path loads since reset.

Behaviour:
- All outputs are registered; latency is 1 cycle from input to output. No combinational path from any input to any output.
- The event priority is evaluated once per rising edge, highest first: reset > req > eret > stall > bubble > load.
- reset:
  - out_pc = RESET_PC.
  - out_valid, out_bd, out_exccode, out_tnew, out_payload all = 0.
  - bubble_cnt = 0.
- req:
  - out_pc = HANDLER_PC.
  - out_valid, out_bd, out_exccode, out_tnew, out_payload all = 0.
  - bubble_cnt unchanged.
- eret:
  - out_pc = epc as sampled this edge.
  - All other fields cleared as for req.
  - bubble_cnt unchanged.
  - eret is ignored if req is also high.
- stall: every output holds its value, including out_tnew (no countdown while held). bubble_cnt unchanged.
- bubble:
  - out_pc = in_pc and out_bd = in_bd, so an exception taken later reports a correct EPC/BD.
  - out_valid, out_exccode, out_tnew, out_payload = 0.
  - bubble_cnt increments, saturating at all-ones.
- load:
  - All fields copy their inputs.
  - out_tnew = (DEC_TNEW and in_tnew != 0) ? in_tnew - 1 : in_tnew.
  - With DEC_TNEW = 1, in_tnew = 0 loads 0; there is no wrap to all-ones.
- A bubble with stall also high holds; stall wins and no count is taken.
- A req or eret with stall also high flushes; redirects override stall.
- bubble_cnt at all-ones plus another bubble stays at all-ones.
- A reset mid-stall or mid-flush takes full effect on the same edge; no residual state survives.
- in_valid = 0 on the load path is legal: the register loads normally and no bubble is counted.
- Flush paths clear exccode, so a flushed slot never re-raises an exception.

Test Plan:
- Reset: reset = 1 for 2 cycles, then release with all inputs 0 -> out_pc = 0x3000, all other outputs and bubble_cnt = 0 during reset; first post-reset edge loads in_pc = 0.
- Load and Tnew: DEC_TNEW = 1, in_pc = 0x3004, in_tnew = 2, in_payload = 0xA5, in_valid = 1, then in_tnew = 0 -> out_tnew = 1 on the first edge and 0 on the second (no wrap); out_payload = 0xA5; out_pc = 0x3004.
- Stall hold: load in_pc = 0x3008, in_tnew = 2, then stall = 1 for 3 cycles with changing inputs -> outputs frozen at pc 0x3008 and tnew 1 for all 3 cycles.
- Bubble: bubble = 1, in_pc = 0x300C, in_bd = 1, in_payload = 0xFF -> out_pc = 0x300C, out_bd = 1, out_valid = 0, out_payload = 0, bubble_cnt = 1; stall = 1 plus bubble = 1 the next cycle -> bubble_cnt stays 1.
- Redirects: req = 1 and eret = 1 with epc = 0x3010 -> out_pc = 0x4180; next cycle eret = 1 only -> out_pc = 0x3010; next cycle req = 1 with stall = 1 -> out_pc = 0x4180, all other fields 0.
- Saturation: CNT_W = 2, apply 5 consecutive bubbles -> bubble_cnt reads 1, 2, 3, 3, 3.
